// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues tagged ALU commands, issues them one at a time and returns in-order responses
module alu_cmd_issuer #(
  parameter int DATA_W      = 32,
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int TAG_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_opcode,
  input  logic [2:0]        cmd_funct,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic              alu_valid,
  output logic [3:0]        alu_opcode,
  output logic [2:0]        alu_funct,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_o,
  input  logic              alu_valid_o,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_overflow,
  output logic              rsp_timeout,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              busy
);
  localparam int AW = $clog2(CMD_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int EW = 7 + 2 * DATA_W + TAG_W;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t            state_q, state_d;
  logic [EW-1:0]     mem_q [CMD_DEPTH];
  logic [EW-1:0]     cmd_q;
  logic [AW-1:0]     wp_q, rp_q;
  logic [AW:0]       cnt_q;
  logic [TW-1:0]     timer_q, timer_d;
  logic [DATA_W-1:0] rdata_q;
  logic              rov_q, rto_q;
  logic              push, pop, tmo, done;
  assign cmd_ready = !rst && cnt_q != (AW+1)'(CMD_DEPTH);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = state_q == IDLE && cnt_q != '0;
  assign tmo       = timer_q == TW'(TIMEOUT_CYC - 1);
  assign done      = state_q == WAIT && (alu_valid_o || tmo);
  assign {alu_opcode, alu_funct, alu_a, alu_b, rsp_tag} = cmd_q;
  assign alu_valid    = state_q == ISSUE;
  assign rsp_valid    = state_q == RESP;
  assign rsp_data     = rdata_q;
  assign rsp_overflow = rov_q;
  assign rsp_timeout  = rto_q;
  assign busy         = state_q != IDLE || cnt_q != '0;
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE:    state_d = pop ? ISSUE : IDLE;
      ISSUE: begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: begin
        state_d = done ? RESP : WAIT;
        timer_d = done ? timer_q : timer_q + TW'(1);
      end
      RESP:    state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cmd_q   <= '0;
      rdata_q <= '0;
      rov_q   <= 1'b0;
      rto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) begin
        rp_q  <= rp_q + 1'b1;
        cmd_q <= mem_q[rp_q];
      end
      // a valid result beats a timeout landing in the same cycle
      if (done) begin
        rdata_q <= alu_valid_o ? alu_o : '0;
        rov_q   <= alu_valid_o && alu_overflow;
        rto_q   <= !alu_valid_o;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {cmd_opcode, cmd_funct, cmd_a, cmd_b, cmd_tag};
  end
endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Requester-side driver for the alu operation interface (valid_i/opcode/funct/a/b in; o/valid_o/overflow out).
- Buffers tagged commands from an upstream valid/ready port in a small FIFO. Issues them to the ALU one at a time with a single-cycle valid pulse, and waits for valid_o or a timeout.
- Returns result, overflow and timeout status to a downstream valid/ready response port, in command order.

Parameters:
DATA_W, 32, operand/result width (matches alu DATA_W)
CMD_DEPTH, 4, command FIFO entries; power of 2, >=2
TIMEOUT_CYC, 64, max WAIT cycles before aborting a request; >=2
TAG_W, 4, width of the opaque command tag

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_opcode  in  4  alu opcode
cmd_funct  in  3  alu funct
cmd_a  in  DATA_W  operand a
cmd_b  in  DATA_W  operand b
cmd_tag  in  TAG_W  tag, echoed on response
alu_valid  out  1  drives alu valid_i
alu_opcode  out  4  drives alu opcode
alu_funct  out  3  drives alu funct
alu_a  out  DATA_W  drives alu a
alu_b  out  DATA_W  drives alu b
alu_o  in  DATA_W  alu result
alu_valid_o  in  1  alu result valid
alu_overflow  in  1  alu overflow
rsp_valid  out  1  response offered
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_data  out  DATA_W  captured alu_o, or 0 on timeout
rsp_overflow  out  1  captured alu_overflow, or 0 on timeout
rsp_timeout  out  1  1 = request aborted by timeout
rsp_tag  out  TAG_W  tag of the command
busy  out  1  FSM != IDLE or FIFO non-empty

Behaviour:

Reset (rst high at a rising edge):
- FIFO is emptied, FSM goes to IDLE, timer = 0.
- alu_valid, alu_opcode, alu_funct, alu_a and alu_b are 0.
- All rsp_* outputs are 0; busy = 0.
- cmd_ready is 0 while rst is high and 1 in the first cycle after.

Command FIFO:
- cmd_ready = !full, derived from the registered count. A push is refused when full, even if a pop happens in the same cycle.
- Simultaneous push and pop when not full leaves the count unchanged.
- Read and write pointers wrap modulo CMD_DEPTH.
- A pop only happens in IDLE when the FIFO is non-empty.

FSM states IDLE, ISSUE, WAIT, RESP:
- IDLE: if the FIFO is non-empty, pop the head into the alu_opcode/funct/a/b registers and the tag register, then go to ISSUE.
- ISSUE: alu_valid = 1 for exactly this cycle, timer cleared, then go to WAIT.
- WAIT:
  - If alu_valid_o = 1: rsp_data <= alu_o, rsp_overflow <= alu_overflow, rsp_timeout <= 0, go to RESP.
  - Else if timer == TIMEOUT_CYC-1: rsp_data <= 0, rsp_overflow <= 0, rsp_timeout <= 1, go to RESP.
  - Else timer++.
  - If alu_valid_o coincides with the final timeout cycle, the valid result wins.
- RESP: rsp_valid = 1, and all rsp_* stay stable until rsp_ready. The handshake returns the FSM to IDLE.

Output and timing rules:
- alu_opcode/funct/a/b hold from the pop until the next pop; they are stable throughout ISSUE and WAIT.
- alu_valid_o is sampled only in WAIT. Pulses in IDLE, ISSUE or RESP are ignored, including a late result after a timeout.
- Minimum latency:
  - A command handshaken in cycle C into an empty, idle block gives alu_valid = 1 in cycle C+2.
  - An alu_valid_o in cycle C+3 gives rsp_valid = 1 in cycle C+4.
- Timeout: with no response, rsp_valid with rsp_timeout = 1 rises in cycle ISSUE+TIMEOUT_CYC+1.
- The timer is $clog2(TIMEOUT_CYC) bits and never wraps.
- Responses are strictly in command order; only one ALU request is outstanding at any time.
- Reset during ISSUE, WAIT or RESP discards the in-flight request and all queued commands; no response is produced for them.

Test Plan:
1. Single command: opcode 0, funct 0, a = 0x0000000F, b = 0x00000003, tag 5; ALU model returns o = 0x00000012 two cycles after valid_i -> alu_valid high exactly one cycle, at C+2; rsp_data = 0x12, rsp_tag = 5, rsp_overflow = 0, rsp_timeout = 0.
2. Backpressure/full: CMD_DEPTH = 4, rsp_ready = 0, cmd_valid held high with tags 0..7 -> exactly 5 commands accepted, then cmd_ready = 0. After rsp_ready = 1, the remaining 3 are accepted and responses arrive with tags 0..7 in order, with no duplicates or losses.
3. Timeout: the model never asserts valid_o -> rsp_valid in cycle ISSUE+65 with rsp_timeout = 1 and rsp_data = 0. A valid_o pulse injected during the RESP that follows is ignored, and the next command completes normally.
4. Boundary race: valid_o (o = 0xA5A5A5A5) arrives in the last WAIT cycle (timer = 63) -> rsp_timeout = 0, rsp_data = 0xA5A5A5A5.
5. Overflow passthrough: the model returns o = 0x80000000 with overflow = 1 -> rsp_overflow = 1, rsp_data = 0x80000000. Operands stay stable on alu_a/alu_b throughout WAIT.
6. Reset mid-WAIT with 2 commands queued -> next cycle busy = 0, alu_valid = 0, rsp_valid = 0, cmd_ready = 1. A later stray valid_o produces no response, and the FIFO is empty.
